// File: rtl/fpu_ch_arbiter.sv
// Shares one FPU between NUM_CH requesters: round-robin issue into a single
// registered stage, per-channel credit limit, tag-routed 1-entry result buffers.
module fpu_ch_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int REQ_W   = 64,
  parameter int DWIDTH  = 16,
  parameter int TAG_W   = 2,
  parameter int MAX_OUT = 2,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NUM_CH*REQ_W-1:0]  ch_req_i,
  input  logic [NUM_CH*TAG_W-1:0]  ch_tag_i,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  output logic [NUM_CH-1:0]        ch_ready_o,
  output logic [NUM_CH*DWIDTH-1:0] ch_result_o,
  output logic [NUM_CH*5-1:0]      ch_status_o,
  output logic [NUM_CH*TAG_W-1:0]  ch_tag_o,
  output logic [NUM_CH-1:0]        ch_rvalid_o,
  input  logic [NUM_CH-1:0]        ch_rready_i,
  output logic [REQ_W-1:0]         fpu_req_o,
  output logic [CH_W+TAG_W-1:0]    fpu_tag_o,
  output logic                     fpu_valid_o,
  input  logic                     fpu_ready_i,
  output logic                     fpu_flush_o,
  input  logic [DWIDTH-1:0]        fpu_result_i,
  input  logic [4:0]               fpu_status_i,
  input  logic [CH_W+TAG_W-1:0]    fpu_tag_i,
  input  logic                     fpu_rvalid_i,
  output logic                     fpu_rready_o,
  output logic                     busy_o
);

  localparam int FT_W  = CH_W + TAG_W;
  localparam int CNT_W = 3;

  logic                           iss_v_q, iss_v_d;
  logic [REQ_W-1:0]               iss_req_q, iss_req_d;
  logic [FT_W-1:0]                iss_tag_q, iss_tag_d;
  logic [CH_W-1:0]                rr_q, rr_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]              rbuf_v_q, rbuf_v_d;
  logic [NUM_CH-1:0][DWIDTH-1:0]  rbuf_res_q, rbuf_res_d;
  logic [NUM_CH-1:0][4:0]         rbuf_st_q, rbuf_st_d;
  logic [NUM_CH-1:0][TAG_W-1:0]   rbuf_tag_q, rbuf_tag_d;

  logic [NUM_CH-1:0] elig, grant, drain;
  logic              can_load, found;
  logic [CH_W-1:0]   win;
  int                idx;
  logic [REQ_W-1:0]  sel_req;
  logic [FT_W-1:0]   sel_tag;
  logic [CH_W-1:0]   fpu_id;
  logic              id_ok, id_full, id_drain, cap;

  // Arbitration: first eligible channel at or after the round-robin pointer.
  always_comb begin
    can_load = rst_ni & ~flush_i & (~iss_v_q | fpu_ready_i);
    found    = 1'b0;
    win      = '0;
    idx      = 0;
    elig     = '0;
    for (int c = 0; c < NUM_CH; c++)
      elig[c] = ch_valid_i[c] && (cnt_q[c] < CNT_W'(MAX_OUT));
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_q) + i) % NUM_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
    grant = '0;
    if (can_load && found) grant[win] = 1'b1;
    sel_req = '0;
    sel_tag = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (win == CH_W'(c)) begin
        sel_req = ch_req_i[c*REQ_W +: REQ_W];
        sel_tag = {CH_W'(c), ch_tag_i[c*TAG_W +: TAG_W]};
      end
    end
  end

  always_comb begin
    fpu_id   = fpu_tag_i[FT_W-1:TAG_W];
    id_ok    = int'(fpu_id) < NUM_CH;
    id_full  = 1'b0;
    id_drain = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (fpu_id == CH_W'(c)) begin
        id_full  = rbuf_v_q[c];
        id_drain = ch_rready_i[c];
      end
    end
    // Unknown ids are always accepted so a stray result cannot stall the FPU.
    fpu_rready_o = rst_ni & (~id_ok | ~id_full | id_drain);
    cap          = fpu_rvalid_i & fpu_rready_o & id_ok & ~flush_i;
  end

  always_comb begin
    iss_v_d    = iss_v_q;
    iss_req_d  = iss_req_q;
    iss_tag_d  = iss_tag_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    rbuf_v_d   = rbuf_v_q;
    rbuf_res_d = rbuf_res_q;
    rbuf_st_d  = rbuf_st_q;
    rbuf_tag_d = rbuf_tag_q;
    drain      = rbuf_v_q & ch_rready_i;
    if (flush_i) begin
      iss_v_d  = 1'b0;
      cnt_d    = '0;
      rbuf_v_d = '0;
    end else begin
      if (~iss_v_q | fpu_ready_i) iss_v_d = |grant;
      if (|grant) begin
        iss_req_d = sel_req;
        iss_tag_d = sel_tag;
        rr_d      = (win == CH_W'(NUM_CH-1)) ? '0 : win + 1'b1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (grant[c] && !drain[c])      cnt_d[c] = cnt_q[c] + 1'b1;
        else if (!grant[c] && drain[c]) cnt_d[c] = cnt_q[c] - 1'b1;
        if (cap && fpu_id == CH_W'(c)) begin
          rbuf_v_d[c]   = 1'b1;
          rbuf_res_d[c] = fpu_result_i;
          rbuf_st_d[c]  = fpu_status_i;
          rbuf_tag_d[c] = fpu_tag_i[TAG_W-1:0];
        end else if (drain[c]) begin
          rbuf_v_d[c] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iss_v_q    <= 1'b0;
      iss_req_q  <= '0;
      iss_tag_q  <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      rbuf_v_q   <= '0;
      rbuf_res_q <= '0;
      rbuf_st_q  <= '0;
      rbuf_tag_q <= '0;
    end else begin
      iss_v_q    <= iss_v_d;
      iss_req_q  <= iss_req_d;
      iss_tag_q  <= iss_tag_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      rbuf_v_q   <= rbuf_v_d;
      rbuf_res_q <= rbuf_res_d;
      rbuf_st_q  <= rbuf_st_d;
      rbuf_tag_q <= rbuf_tag_d;
    end
  end

  assign ch_ready_o  = grant;
  assign ch_rvalid_o = rbuf_v_q;
  assign ch_result_o = rbuf_res_q;
  assign ch_status_o = rbuf_st_q;
  assign ch_tag_o    = rbuf_tag_q;
  assign fpu_valid_o = iss_v_q;
  assign fpu_req_o   = iss_req_q;
  assign fpu_tag_o   = iss_tag_q;
  assign fpu_flush_o = flush_i & rst_ni;
  assign busy_o      = |cnt_q;

endmodule

// File: tb/tb_fpu_ch_arbiter.sv
// Directed bench for fpu_ch_arbiter; the bench itself plays the FPU side.
module tb_fpu_ch_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         flush_i;
  logic [255:0] ch_req_i;
  logic [7:0]   ch_tag_i;
  logic [3:0]   ch_valid_i;
  logic [3:0]   ch_ready_o;
  logic [63:0]  ch_result_o;
  logic [19:0]  ch_status_o;
  logic [7:0]   ch_tag_o;
  logic [3:0]   ch_rvalid_o;
  logic [3:0]   ch_rready_i;
  logic [63:0]  fpu_req_o;
  logic [3:0]   fpu_tag_o;
  logic         fpu_valid_o;
  logic         fpu_ready_i;
  logic         fpu_flush_o;
  logic [15:0]  fpu_result_i;
  logic [4:0]   fpu_status_i;
  logic [3:0]   fpu_tag_i;
  logic         fpu_rvalid_i;
  logic         fpu_rready_o;
  logic         busy_o;

  int n_cmp = 0;
  int n_err = 0;

  fpu_ch_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .ch_req_i(ch_req_i), .ch_tag_i(ch_tag_i), .ch_valid_i(ch_valid_i),
    .ch_ready_o(ch_ready_o), .ch_result_o(ch_result_o), .ch_status_o(ch_status_o),
    .ch_tag_o(ch_tag_o), .ch_rvalid_o(ch_rvalid_o), .ch_rready_i(ch_rready_i),
    .fpu_req_o(fpu_req_o), .fpu_tag_o(fpu_tag_o), .fpu_valid_o(fpu_valid_o),
    .fpu_ready_i(fpu_ready_i), .fpu_flush_o(fpu_flush_o), .fpu_result_i(fpu_result_i),
    .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i), .fpu_rvalid_i(fpu_rvalid_i),
    .fpu_rready_o(fpu_rready_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    flush_i      = 1'b0;
    ch_req_i     = '0;
    ch_tag_i     = '0;
    ch_valid_i   = '0;
    ch_rready_i  = '0;
    fpu_ready_i  = 1'b0;
    fpu_result_i = '0;
    fpu_status_i = '0;
    fpu_tag_i    = '0;
    fpu_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic set_req(input int c, input logic [63:0] v);
    ch_req_i[c*64 +: 64] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst_ni = 1'b0;

    // T1: random inputs while held in reset
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) set_req(c, {$urandom(), $urandom()});
      ch_tag_i     = 8'($urandom());
      ch_valid_i   = 4'($urandom()) | 4'b0001;
      ch_rready_i  = 4'($urandom());
      fpu_ready_i  = 1'($urandom());
      fpu_rvalid_i = 1'b1;
      fpu_tag_i    = 4'($urandom());
      fpu_result_i = 16'($urandom());
      flush_i      = 1'($urandom());
      tick();
      chk("t1_ready", ch_ready_o, 0);
      chk("t1_rvalid", ch_rvalid_o, 0);
      chk("t1_fvalid", fpu_valid_o, 0);
      chk("t1_freq", fpu_req_o, 0);
      chk("t1_rready", fpu_rready_o, 0);
      chk("t1_flush", fpu_flush_o, 0);
      chk("t1_busy", busy_o, 0);
      chk("t1_result", ch_result_o, 0);
    end
    idle_inputs();
    rst_ni = 1'b1;
    tick();
    ch_valid_i = 4'b0001;
    settle();
    chk("t1_first_grant", ch_ready_o, 4'b0001);
    ch_valid_i = 4'b0000;

    // T2: round-robin over all four channels, then credit limit on channel 0
    do_reset();
    fpu_ready_i = 1'b1;
    ch_valid_i  = 4'hF;
    for (int c = 0; c < 4; c++) begin
      set_req(c, 64'hA000 + 64'(c));
      ch_tag_i[c*2 +: 2] = 2'(c);
    end
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("t2_grant", ch_ready_o, 64'(1 << (k % 4)));
      if (k > 0) begin
        chk("t2_tag_ch", fpu_tag_o[3:2], 64'((k - 1) % 4));
        chk("t2_req", fpu_req_o, 64'hA000 + 64'((k - 1) % 4));
      end
      tick();
    end
    settle();
    chk("t2_all_blocked", ch_ready_o, 0);
    chk("t2_last_tag_ch", fpu_tag_o[3:2], 3);
    tick();
    chk("t2_stage_empty", fpu_valid_o, 0);
    chk("t2_busy", busy_o, 1);
    fpu_rvalid_i = 1'b1;
    fpu_tag_i    = 4'b0000;
    fpu_result_i = 16'h1111;
    settle();
    chk("t2_frready", fpu_rready_o, 1);
    tick();
    fpu_rvalid_i = 1'b0;
    settle();
    chk("t2_rvalid0", ch_rvalid_o, 4'b0001);
    chk("t2_res0", ch_result_o[15:0], 16'h1111);
    chk("t2_still_blocked", ch_ready_o, 0);
    ch_rready_i = 4'b0001;
    tick();
    ch_rready_i = 4'b0000;
    settle();
    chk("t2_unblocked", ch_ready_o, 4'b0001);
    chk("t2_rvalid_clr", ch_rvalid_o, 0);

    // T3: FPU backpressure holds the issue stage
    do_reset();
    ch_valid_i = 4'b0001;
    set_req(0, 64'hDEAD_BEEF_0123_4567);
    settle();
    chk("t3_grantA", ch_ready_o, 4'b0001);
    tick();
    ch_valid_i = 4'b0011;
    set_req(1, 64'h0BBB_0000_1111_2222);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t3_fvalid", fpu_valid_o, 1);
      chk("t3_reqA", fpu_req_o, 64'hDEAD_BEEF_0123_4567);
      chk("t3_no_grant", ch_ready_o, 0);
      tick();
    end
    fpu_ready_i = 1'b1;
    settle();
    chk("t3_grantB", ch_ready_o, 4'b0010);
    tick();
    ch_valid_i = 4'b0000;
    settle();
    chk("t3_reqB", fpu_req_o, 64'h0BBB_0000_1111_2222);
    chk("t3_tagB_ch", fpu_tag_o[3:2], 1);

    // T4: result routed to channel 2
    do_reset();
    fpu_ready_i = 1'b1;
    ch_valid_i  = 4'b0100;
    tick();
    ch_valid_i = 4'b0000;
    tick();
    fpu_rvalid_i = 1'b1;
    fpu_tag_i    = 4'b1011;
    fpu_result_i = 16'h3C00;
    fpu_status_i = 5'b00001;
    settle();
    chk("t4_frready", fpu_rready_o, 1);
    tick();
    fpu_rvalid_i = 1'b0;
    settle();
    chk("t4_rvalid", ch_rvalid_o, 4'b0100);
    chk("t4_result", ch_result_o[47:32], 16'h3C00);
    chk("t4_status", ch_status_o[14:10], 5'b00001);
    chk("t4_tag", ch_tag_o[5:4], 3);
    chk("t4_busy", busy_o, 1);
    ch_rready_i = 4'b0100;
    tick();
    ch_rready_i = 4'b0000;
    settle();
    chk("t4_rvalid_clr", ch_rvalid_o, 0);
    chk("t4_idle", busy_o, 0);

    // T5: full result buffer stalls the FPU, then capture-with-drain
    do_reset();
    fpu_ready_i = 1'b1;
    ch_valid_i  = 4'b0010;
    settle();
    chk("t5_grant1", ch_ready_o, 4'b0010);
    tick();
    settle();
    chk("t5_grant2", ch_ready_o, 4'b0010);
    tick();
    ch_valid_i = 4'b0000;
    tick();
    fpu_rvalid_i = 1'b1;
    fpu_tag_i    = 4'b0100;
    fpu_result_i = 16'hAAAA;
    tick();
    fpu_tag_i    = 4'b0101;
    fpu_result_i = 16'hBBBB;
    settle();
    chk("t5_stall", fpu_rready_o, 0);
    tick();
    chk("t5_hold_res", ch_result_o[31:16], 16'hAAAA);
    chk("t5_hold_v", ch_rvalid_o, 4'b0010);
    ch_rready_i = 4'b0010;
    settle();
    chk("t5_pass", fpu_rready_o, 1);
    tick();
    fpu_rvalid_i = 1'b0;
    ch_rready_i  = 4'b0000;
    settle();
    chk("t5_new_v", ch_rvalid_o, 4'b0010);
    chk("t5_new_res", ch_result_o[31:16], 16'hBBBB);
    chk("t5_new_tag", ch_tag_o[3:2], 1);
    chk("t5_busy", busy_o, 1);
    ch_rready_i = 4'b0010;
    tick();
    ch_rready_i = 4'b0000;
    settle();
    chk("t5_empty", ch_rvalid_o, 0);
    chk("t5_idle", busy_o, 0);

    // T6: flush with three ops in flight and a late result
    do_reset();
    fpu_ready_i = 1'b1;
    ch_valid_i  = 4'b0111;
    tick();
    tick();
    tick();
    ch_valid_i   = 4'b0000;
    fpu_rvalid_i = 1'b1;
    fpu_tag_i    = 4'b0000;
    fpu_result_i = 16'h5555;
    tick();
    fpu_tag_i  = 4'b0100;
    flush_i    = 1'b1;
    ch_valid_i = 4'hF;
    settle();
    chk("t6_fflush", fpu_flush_o, 1);
    chk("t6_ready_forced", ch_ready_o, 0);
    chk("t6_pre_rvalid", ch_rvalid_o, 4'b0001);
    tick();
    flush_i      = 1'b0;
    fpu_rvalid_i = 1'b0;
    ch_valid_i   = 4'b0000;
    settle();
    chk("t6_fflush_off", fpu_flush_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_rvalid", ch_rvalid_o, 0);
    chk("t6_fvalid", fpu_valid_o, 0);
    ch_valid_i = 4'b1001;
    settle();
    chk("t6_rr_kept", ch_ready_o, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
